audio_capture_sequencer: RTL and testbench

// Sequences stereo capture out of the left/right audio sample FIFOs: arm, wait for trigger,

---
 rtl/audio_capture_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_audio_capture_sequencer.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_capture_sequencer.sv
// -----------------------------------------------------------------------------
// audio_capture_sequencer
//
// Purpose:
//   Sequences stereo capture out of the left/right audio sample FIFOs. A
//   capture is armed, optionally waits for an external trigger, then pops
//   matched L/R pairs and presents them one word at a time (L first, then R)
//   to a valid/ready sink. It also drives i2s_enable upstream and keeps a
//   sticky FIFO-overrun flag.
//
// Configuration macro:
//   AUDSEQ_PRETRIG_FLUSH_EN - when defined, both FIFOs are drained and the
//   data discarded while waiting for the trigger, so the first captured pair
//   is fresh post-trigger data. Overrun is not flagged while waiting.
//   Undefined (default): FIFOs are untouched while waiting.
//
// Ports:
//   clk, reset_n          system clock / synchronous active-low reset
//   cfg_arm, cfg_abort    1-cycle control pulses (abort wins over arm)
//   cfg_trig_mode         0 = start immediately, 1 = ext_trig rising edge
//   cfg_sample_count      pairs to capture, 0 = continuous
//   ext_trig              external trigger, synchronous to clk
//   fifo_*_empty/_full    FIFO status flags
//   fifo_*_q              FIFO read data, valid the cycle after rdreq
//   fifo_*_rdreq          FIFO pops, always issued together
//   out_valid/out_ready   sink handshake; out_data/out_chan (0=L, 1=R)
//   i2s_enable, busy      high whenever not idle
//   done, overrun         sticky status, cleared by an accepted arm
//   pairs_done            pairs delivered in the current/last capture
//
// Handshake: a word transfers on a clock edge where out_valid && out_ready.
// While out_valid is high, out_data/out_chan stay stable until the transfer.
// -----------------------------------------------------------------------------
module audio_capture_sequencer #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_arm,
    input  logic                     cfg_abort,
    input  logic                     cfg_trig_mode,
    input  logic [CNT_WIDTH-1:0]     cfg_sample_count,
    input  logic                     ext_trig,
    input  logic                     fifo_l_empty,
    input  logic                     fifo_r_empty,
    input  logic                     fifo_l_full,
    input  logic                     fifo_r_full,
    input  logic [AUD_BIT_DEPTH-1:0] fifo_l_q,
    input  logic [AUD_BIT_DEPTH-1:0] fifo_r_q,
    output logic                     fifo_l_rdreq,
    output logic                     fifo_r_rdreq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AUD_BIT_DEPTH-1:0] out_data,
    output logic                     out_chan,
    output logic                     i2s_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [CNT_WIDTH-1:0]     pairs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_FETCH,
        S_LATCH,
        S_OUT_L,
        S_OUT_R
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state;
    state_t                   state_nx;
    logic [CNT_WIDTH-1:0]     count_r;
    logic                     trig_mode_r;
    logic                     trig_q;
    logic                     trig_rise;
    logic [AUD_BIT_DEPTH-1:0] hold_l;
    logic [AUD_BIT_DEPTH-1:0] hold_r;
    logic                     fifo_rd;
    logic                     accept_pair;
    logic                     arm_go;
    logic                     last_pair;
    logic                     ovr_window;
    logic [CNT_WIDTH-1:0]     pairs_inc;

    assign arm_go    = (state == S_IDLE) && cfg_arm && !cfg_abort;
    assign pairs_inc = pairs_done + CNT_ONE;
    // A zero count means continuous capture, so it never terminates here.
    assign last_pair = (count_r != '0) && (pairs_inc == count_r);

    assign i2s_enable   = (state != S_IDLE);
    assign busy         = (state != S_IDLE);
    assign fifo_l_rdreq = fifo_rd;
    assign fifo_r_rdreq = fifo_rd;

`ifdef AUDSEQ_PRETRIG_FLUSH_EN
    // The pre-trigger flush deliberately lets the FIFOs run; a full flag
    // there is expected and not an overrun.
    assign ovr_window = i2s_enable && (state != S_WAIT_TRIG);
`else
    assign ovr_window = i2s_enable;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            count_r     <= '0;
            trig_mode_r <= 1'b0;
            trig_q      <= 1'b0;
            trig_rise   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            pairs_done  <= '0;
        end else begin
            state     <= state_nx;
            // Registered edge detect: a rising ext_trig is seen one cycle late.
            trig_q    <= ext_trig;
            trig_rise <= ext_trig & ~trig_q;

            if (arm_go) begin
                count_r     <= cfg_sample_count;
                trig_mode_r <= cfg_trig_mode;
                done        <= 1'b0;
                overrun     <= 1'b0;
                pairs_done  <= '0;
            end

            if (state == S_LATCH) begin
                hold_l <= fifo_l_q;
                hold_r <= fifo_r_q;
            end

            if (accept_pair) begin
                pairs_done <= pairs_inc;
                if (last_pair) begin
                    done <= 1'b1;
                end
            end

            if (ovr_window && (fifo_l_full || fifo_r_full)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        fifo_rd     = 1'b0;
        out_valid   = 1'b0;
        out_chan    = 1'b0;
        out_data    = '0;
        accept_pair = 1'b0;

        case (state)
            S_IDLE: begin
                if (cfg_arm) begin
                    state_nx = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (!trig_mode_r || trig_rise) begin
                    state_nx = S_FETCH;
                end
`ifdef AUDSEQ_PRETRIG_FLUSH_EN
                if (!fifo_l_empty && !fifo_r_empty) begin
                    fifo_rd = 1'b1;
                end
`endif
            end
            S_FETCH: begin
                // Pop only when both sides have data so L and R stay paired.
                if (!fifo_l_empty && !fifo_r_empty) begin
                    fifo_rd  = 1'b1;
                    state_nx = S_LATCH;
                end
            end
            S_LATCH: begin
                state_nx = S_OUT_L;
            end
            S_OUT_L: begin
                out_valid = 1'b1;
                out_data  = hold_l;
                if (out_ready) begin
                    state_nx = S_OUT_R;
                end
            end
            S_OUT_R: begin
                out_valid = 1'b1;
                out_chan  = 1'b1;
                out_data  = hold_r;
                if (out_ready) begin
                    accept_pair = 1'b1;
                    state_nx    = last_pair ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Abort overrides everything: no pair is counted and done stays clear.
        if (cfg_abort) begin
            state_nx    = S_IDLE;
            accept_pair = 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_capture_sequencer.sv
`timescale 1ns/1ps
module tb_audio_capture_sequencer;

    localparam int AW = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_arm = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          cfg_trig_mode = 1'b0;
    logic [CW-1:0] cfg_sample_count = '0;
    logic          ext_trig = 1'b0;
    logic          fifo_l_empty = 1'b1;
    logic          fifo_r_empty = 1'b1;
    logic          fifo_l_full = 1'b0;
    logic          fifo_r_full = 1'b0;
    logic [AW-1:0] fifo_l_q = '0;
    logic [AW-1:0] fifo_r_q = '0;
    logic          fifo_l_rdreq;
    logic          fifo_r_rdreq;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_data;
    logic          out_chan;
    logic          i2s_enable;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [CW-1:0] pairs_done;

    // FIFO contents model and scoreboard ({chan, data} per word)
    logic [AW-1:0] l_mem[$];
    logic [AW-1:0] r_mem[$];
    logic [AW:0]   exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int pair_viol = 0;
    int underflow = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    audio_capture_sequencer #(.AUD_BIT_DEPTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_trig_mode(cfg_trig_mode),
        .cfg_sample_count(cfg_sample_count), .ext_trig(ext_trig),
        .fifo_l_empty(fifo_l_empty), .fifo_r_empty(fifo_r_empty),
        .fifo_l_full(fifo_l_full), .fifo_r_full(fifo_r_full),
        .fifo_l_q(fifo_l_q), .fifo_r_q(fifo_r_q),
        .fifo_l_rdreq(fifo_l_rdreq), .fifo_r_rdreq(fifo_r_rdreq),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .i2s_enable(i2s_enable), .busy(busy),
        .done(done), .overrun(overrun), .pairs_done(pairs_done)
    );

    // FIFO read side: data appears the cycle after rdreq.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_l_rdreq !== fifo_r_rdreq) pair_viol <= pair_viol + 1;
        if (fifo_l_rdreq === 1'b1) begin
            if (l_mem.size() != 0) fifo_l_q <= l_mem.pop_front();
            else underflow <= underflow + 1;
        end
        if (fifo_r_rdreq === 1'b1) begin
            if (r_mem.size() != 0) fifo_r_q <= r_mem.pop_front();
            else underflow <= underflow + 1;
        end
    end

    always @(negedge clk) begin
        #1;
        fifo_l_empty = (l_mem.size() == 0);
        fifo_r_empty = (r_mem.size() == 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_pair(input logic [AW-1:0] l, input logic [AW-1:0] r, input bit expect_out);
        l_mem.push_back(l);
        r_mem.push_back(r);
        if (expect_out) begin
            exp_q.push_back({1'b0, l});
            exp_q.push_back({1'b1, r});
        end
    endtask

    task automatic arm(input logic mode, input logic [CW-1:0] count);
        tick();
        cfg_trig_mode    = mode;
        cfg_sample_count = count;
        cfg_arm          = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, i2s_enable, out_valid, fifo_l_rdreq, fifo_r_rdreq, done, overrun} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, i2s_enable, out_valid, fifo_l_rdreq, fifo_r_rdreq, done, overrun});
        end
        n_cmp++;
        if (pairs_done !== '0 || out_data !== '0 || out_chan !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: pairs_done %h out_data %h out_chan %b required all 0",
                     pairs_done, out_data, out_chan);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int got = 0;
        int t_arm;
        int t_prev = -1;
        logic [AW:0] act;
        logic [AW:0] exp;
        for (int i = 0; i < 3; i++) push_pair(24'h000011 + 24'(i), 24'h0000A1 + 24'(i), 1'b1);
        out_ready = 1'b1;
        tick(); tick();
        arm(1'b0, 16'd3);
        t_arm = cyc;
        for (int k = 0; k < 60 && got < 6; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL basic_extra_word: got %h, nothing expected", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_err++;
                        $display("FAIL basic_word%0d: got %h required %h", got, act, exp);
                    end
                end
                if (!out_chan) begin
                    n_cmp++;
                    if (t_prev < 0 && cyc - t_arm != 3) begin
                        n_err++;
                        $display("FAIL basic_first_latency: got %0d cycles required 3", cyc - t_arm);
                    end else if (t_prev >= 0 && cyc - t_prev != 4) begin
                        n_err++;
                        $display("FAIL basic_pair_period: got %0d cycles required 4", cyc - t_prev);
                    end
                    t_prev = cyc;
                end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 6) begin
            n_err++;
            $display("FAIL basic_timeout: got %0d words required 6", got);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || pairs_done !== 16'd3 || i2s_enable !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: done %b busy %b pairs_done %0d i2s %b required 1 0 3 0",
                     done, busy, pairs_done, i2s_enable);
        end
    endtask

`ifndef AUDSEQ_PRETRIG_FLUSH_EN
    task automatic test_trigger();
        int viol = 0;
        logic [AW:0] exp;
        push_pair(24'h000777, 24'h000888, 1'b1);
        out_ready = 1'b1;
        ext_trig  = 1'b0;
        tick(); tick();
        arm(1'b1, 16'd1);
        for (int k = 0; k < 50; k++) begin
            if (fifo_l_rdreq || fifo_r_rdreq || !busy || out_valid) viol++;
            tick();
        end
        n_cmp++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL trig_wait_idle: got %0d bad cycles required 0", viol);
        end
        ext_trig = 1'b1;
        tick();
        n_cmp++;
        if (fifo_l_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL trig_rdreq_plus1: got %b required 0", fifo_l_rdreq);
        end
        tick();
        n_cmp++;
        if (fifo_l_rdreq !== 1'b1 || fifo_r_rdreq !== 1'b1) begin
            n_err++;
            $display("FAIL trig_rdreq_plus2: got %b%b required 11", fifo_l_rdreq, fifo_r_rdreq);
        end
        tick(); tick();
        for (int w = 0; w < 2; w++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== exp) begin
                n_err++;
                $display("FAIL trig_word%0d: valid %b got %h required %h", w, out_valid, {out_chan, out_data}, exp);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || pairs_done !== 16'd1) begin
            n_err++;
            $display("FAIL trig_end: done %b busy %b pairs_done %0d required 1 0 1", done, busy, pairs_done);
        end
        ext_trig = 1'b0;
        tick();
    endtask
`else
    task automatic test_flush();
        int got = 0;
        logic [AW:0] act;
        logic [AW:0] exp;
        for (int i = 0; i < 8; i++) push_pair(24'h000900 + 24'(i), 24'h000A00 + 24'(i), 1'b0);
        out_ready = 1'b1;
        ext_trig  = 1'b0;
        tick(); tick();
        arm(1'b1, 16'd2);
        for (int k = 0; k < 30; k++) begin
            fifo_l_full = (k == 10);
            tick();
        end
        fifo_l_full = 1'b0;
        n_cmp++;
        if (l_mem.size() != 0 || r_mem.size() != 0) begin
            n_err++;
            $display("FAIL flush_discard: left %0d right %0d entries remain, required 0", l_mem.size(), r_mem.size());
        end
        n_cmp++;
        if (overrun !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait_state: overrun %b busy %b valid %b required 0 1 0", overrun, busy, out_valid);
        end
        ext_trig = 1'b1;
        tick(); tick();
        push_pair(24'h000B00, 24'h000C00, 1'b1);
        push_pair(24'h000B01, 24'h000C01, 1'b1);
        for (int k = 0; k < 40 && got < 4; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL flush_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 4 || done !== 1'b1 || pairs_done !== 16'd2) begin
            n_err++;
            $display("FAIL flush_end: words %0d done %b pairs_done %0d required 4 1 2", got, done, pairs_done);
        end
        ext_trig = 1'b0;
        tick();
    endtask
`endif

    task automatic test_ready_stall();
        int bad = 0;
        int got = 0;
        logic [AW:0] act;
        logic [AW:0] exp;
        push_pair(24'h000333, 24'h000444, 1'b1);
        push_pair(24'h000555, 24'h000666, 1'b1);
        out_ready = 1'b0;
        tick(); tick();
        arm(1'b0, 16'd2);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || out_chan !== 1'b0 || out_data !== 24'h000333 || fifo_l_rdreq || fifo_r_rdreq) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d unstable cycles required 0", bad);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got < 4; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL stall_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 4 || done !== 1'b1 || pairs_done !== 16'd2) begin
            n_err++;
            $display("FAIL stall_end: words %0d done %b pairs_done %0d required 4 1 2", got, done, pairs_done);
        end
    endtask

    task automatic test_abort();
        int got = 0;
        logic [AW:0] act;
        logic [AW:0] exp;
        for (int i = 0; i < 5; i++) push_pair(24'h000100 + 24'(i), 24'h000200 + 24'(i), 1'b1);
        out_ready = 1'b1;
        tick(); tick();
        arm(1'b0, 16'd5);
        for (int k = 0; k < 40 && got < 4; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL abort_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        exp = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_chan, out_data} !== exp) begin
            n_err++;
            $display("FAIL abort_third_l: valid %b got %h required %h", out_valid, {out_chan, out_data}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_out_r: valid %b chan %b required 1 1", out_valid, out_chan);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || i2s_enable !== 1'b0 || fifo_l_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: valid %b busy %b i2s %b rdreq %b required 0000",
                     out_valid, busy, i2s_enable, fifo_l_rdreq);
        end
        tick(); tick();
        n_cmp++;
        if (done !== 1'b0 || pairs_done !== 16'd2) begin
            n_err++;
            $display("FAIL abort_status: done %b pairs_done %0d required 0 2", done, pairs_done);
        end
        exp_q.delete();
        l_mem.delete();
        r_mem.delete();
        tick(); tick();
    endtask

    task automatic test_overrun();
        int got = 0;
        logic [AW:0] act;
        logic [AW:0] exp;
        for (int i = 0; i < 3; i++) push_pair(24'h000D00 + 24'(i), 24'h000E00 + 24'(i), 1'b1);
        out_ready = 1'b0;
        tick(); tick();
        arm(1'b0, 16'd3);
        tick();
        fifo_r_full = 1'b1;
        tick();
        fifo_r_full = 1'b0;
        tick();
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got < 6; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL overrun_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        tick();
        n_cmp++;
        if (got != 6 || busy !== 1'b0 || done !== 1'b1 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: words %0d busy %b done %b overrun %b required 6 0 1 1",
                     got, busy, done, overrun);
        end
        push_pair(24'h000F00, 24'h000F80, 1'b1);
        tick();
        arm(1'b0, 16'd1);
        n_cmp++;
        if (overrun !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_cleared_by_arm: overrun %b done %b required 0 0", overrun, done);
        end
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL overrun_rearm_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        fifo_l_full = 1'b1;
        tick();
        fifo_l_full = 1'b0;
        tick();
        n_cmp++;
        if (got != 2 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_idle_ignored: words %0d busy %b overrun %b required 2 0 0", got, busy, overrun);
        end
    endtask

    task automatic test_continuous();
        int got = 0;
        logic [AW:0] act;
        logic [AW:0] exp;
        for (int i = 0; i < 3; i++) push_pair(24'h001000 + 24'(i), 24'h002000 + 24'(i), 1'b1);
        out_ready = 1'b1;
        tick(); tick();
        arm(1'b0, 16'd0);
        for (int k = 0; k < 60 && got < 6; k++) begin
            if (out_valid && out_ready) begin
                act = {out_chan, out_data};
                exp = exp_q.pop_front();
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL cont_word%0d: got %h required %h", got, act, exp);
                end
                got++;
            end
            tick();
        end
        repeat (4) tick();
        n_cmp++;
        if (got != 6 || busy !== 1'b1 || done !== 1'b0 || pairs_done !== 16'd3) begin
            n_err++;
            $display("FAIL cont_running: words %0d busy %b done %b pairs_done %0d required 6 1 0 3",
                     got, busy, done, pairs_done);
        end
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || pairs_done !== 16'd3) begin
            n_err++;
            $display("FAIL cont_arm_ignored: busy %b pairs_done %0d required 1 3", busy, pairs_done);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || pairs_done !== 16'd3) begin
            n_err++;
            $display("FAIL cont_abort: busy %b done %b pairs_done %0d required 0 0 3", busy, done, pairs_done);
        end
    endtask

    task automatic test_arm_abort_same();
        cfg_arm   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || i2s_enable !== 1'b0) begin
            n_err++;
            $display("FAIL arm_abort_same: busy %b i2s %b required 0 0", busy, i2s_enable);
        end
    endtask

    task automatic test_pairing();
        n_cmp++;
        if (pair_viol != 0 || underflow != 0) begin
            n_err++;
            $display("FAIL pop_pairing: unmatched pops %0d empty pops %0d required 0 0", pair_viol, underflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifndef AUDSEQ_PRETRIG_FLUSH_EN
        test_trigger();
`else
        test_flush();
`endif
        test_ready_stall();
        test_abort();
        test_overrun();
        test_continuous();
        test_arm_abort_same();
        test_pairing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
